// File: rtl/gamepad_pkg.sv
// Shared types and constants for the GuyBox multi-pad scanner:
// FSM state encoding, button bit positions and pad data-line positions.
package gamepad_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEL_HI = 2'd1,
      SEL_LO = 2'd2,
      COMMIT = 2'd3
   } state_t;

   localparam int BTN_UP    = 0;
   localparam int BTN_DOWN  = 1;
   localparam int BTN_LEFT  = 2;
   localparam int BTN_RIGHT = 3;
   localparam int BTN_A     = 4;
   localparam int BTN_B     = 5;
   localparam int BTN_C     = 6;
   localparam int BTN_START = 7;

   localparam int PIN0 = 0;
   localparam int PIN1 = 1;
   localparam int PIN2 = 2;
   localparam int PIN3 = 3;
   localparam int PIN5 = 4;
   localparam int PIN8 = 5;

   // Lines are active-low; the returned word is active-high.
   function automatic logic [7:0] decode_raw(input logic [5:0] hi_n,
                                             input logic       a_n,
                                             input logic       start_n);
      logic [7:0] w;
      w            = '0;
      w[BTN_UP]    = ~hi_n[PIN0];
      w[BTN_DOWN]  = ~hi_n[PIN1];
      w[BTN_LEFT]  = ~hi_n[PIN2];
      w[BTN_RIGHT] = ~hi_n[PIN3];
      w[BTN_B]     = ~hi_n[PIN5];
      w[BTN_C]     = ~hi_n[PIN8];
      w[BTN_A]     = ~a_n;
      w[BTN_START] = ~start_n;
      return w;
   endfunction

endpackage

// File: rtl/gamepad_scanner_if.sv
// Report bus from the scanner to the CPU-side input registers.
// scan_valid is a one-cycle strobe with no ready: the consumer must take
// buttons/pressed/released/pad_present in the cycle scan_valid is high.
interface gamepad_scanner_if #(parameter int NUM_PADS = 2);
   logic [8*NUM_PADS-1:0] buttons;
   logic [8*NUM_PADS-1:0] pressed;
   logic [8*NUM_PADS-1:0] released;
   logic [NUM_PADS-1:0]   pad_present;
   logic                  scan_valid;

   modport master (output buttons, pressed, released, pad_present, scan_valid);
   modport slave  (input  buttons, pressed, released, pad_present, scan_valid);
endinterface

// File: rtl/pad_debounce.sv
// Per-pad button word debouncer with press/release edge pulses.
// GAMEPAD_DEBOUNCE_EN selects the candidate/counter filter; otherwise raw passes through.
module pad_debounce
`ifdef GAMEPAD_DEBOUNCE_EN
#(
   parameter int DEBOUNCE_SCANS = 2
)
`endif
(
   input  logic       clk,
   input  logic       reset,
   input  logic       commit,
   input  logic [7:0] raw,
   output logic [7:0] stable,
   output logic [7:0] pressed,
   output logic [7:0] released
);

   logic [7:0] stable_q, stable_d;
   logic [7:0] pressed_q, pressed_d;
   logic [7:0] released_q, released_d;

`ifdef GAMEPAD_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

   logic [7:0]    cand_q, cand_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (commit) begin
         if (raw == cand_q) begin
            if (cnt_q != CW'(DEBOUNCE_SCANS)) cnt_d = cnt_q + CW'(1);
         end else begin
            cand_d = raw;
            cnt_d  = CW'(1);
         end
         if (cnt_d == CW'(DEBOUNCE_SCANS)) stable_d = cand_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cand_q <= '0;
         cnt_q  <= '0;
      end else begin
         cand_q <= cand_d;
         cnt_q  <= cnt_d;
      end
   end
`else
   always_comb begin
      stable_d = commit ? raw : stable_q;
   end
`endif

   // Pulses are loaded by the commit strobe and so last exactly one cycle.
   always_comb begin
      pressed_d  = commit ? (stable_d & ~stable_q) : 8'h00;
      released_d = commit ? (~stable_d & stable_q) : 8'h00;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         stable_q   <= '0;
         pressed_q  <= '0;
         released_q <= '0;
      end else begin
         stable_q   <= stable_d;
         pressed_q  <= pressed_d;
         released_q <= released_d;
      end
   end

   assign stable   = stable_q;
   assign pressed  = pressed_q;
   assign released = released_q;

endmodule

// File: rtl/gamepad_scanner.sv
// Multi-pad select-multiplexed gamepad front end: synchroniser, scan FSM, decode.
// Define GAMEPAD_DEBOUNCE_EN to enable per-pad debouncing in pad_debounce.
module gamepad_scanner
   import gamepad_pkg::*;
#(
   parameter int NUM_PADS       = 2,
   parameter int SEL_HOLD       = 16,
   parameter int SCAN_PERIOD    = 1024,
   parameter int DEBOUNCE_SCANS = 2
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [6*NUM_PADS-1:0] pad_data,
   output logic                  pad_sel,
   output logic [1:0]            curr,
   gamepad_scanner_if.master     rpt
);

   localparam int MAX_HOLD = (SCAN_PERIOD > SEL_HOLD) ? SCAN_PERIOD : SEL_HOLD;
   localparam int TW       = $clog2(MAX_HOLD + 1);

   if (NUM_PADS < 1 || SEL_HOLD < 3 || SCAN_PERIOD < 1 || DEBOUNCE_SCANS < 1) begin : g_bad_params
      $error("gamepad_scanner: parameter out of range");
   end

   logic [NUM_PADS-1:0][5:0] sync1_q, sync1_d;
   logic [NUM_PADS-1:0][5:0] sync2_q, sync2_d;
   logic [NUM_PADS-1:0][5:0] hi_q, hi_d;
   logic [NUM_PADS-1:0]      present_q, present_d;
   logic [NUM_PADS-1:0]      present_now;
   logic [NUM_PADS-1:0][7:0] raw;
   logic [NUM_PADS-1:0][7:0] stable, pressed, released;
   state_t                   curr_q, curr_d;
   logic [TW-1:0]            timer_q, timer_d;
   logic                     commit;

   always_comb begin
      sync1_d = pad_data;
      sync2_d = sync1_q;
   end

   always_comb begin
      curr_d    = curr_q;
      timer_d   = timer_q + TW'(1);
      hi_d      = hi_q;
      present_d = present_q;
      commit    = 1'b0;
      case (curr_q)
         IDLE: begin
            if (timer_q == TW'(SCAN_PERIOD - 1)) curr_d = SEL_HI;
         end
         SEL_HI: begin
            if (timer_q == TW'(SEL_HOLD - 1)) begin
               hi_d   = sync2_q;
               curr_d = SEL_LO;
            end
         end
         SEL_LO: begin
            // The sel-low sample is consumed directly on its last cycle, so the
            // committed results are already registered while COMMIT is active.
            if (timer_q == TW'(SEL_HOLD - 1)) begin
               commit    = 1'b1;
               present_d = present_now;
               curr_d    = COMMIT;
            end
         end
         COMMIT: begin
            curr_d = IDLE;
         end
         default: begin
            curr_d = IDLE;
         end
      endcase
      if (curr_d != curr_q) timer_d = '0;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_q   <= '1;
         sync2_q   <= '1;
         hi_q      <= '1;
         present_q <= '0;
         curr_q    <= IDLE;
         timer_q   <= '0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         hi_q      <= hi_d;
         present_q <= present_d;
         curr_q    <= curr_d;
         timer_q   <= timer_d;
      end
   end

   for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
      assign present_now[p] = ~sync2_q[p][PIN2] & ~sync2_q[p][PIN3];
      assign raw[p] = present_now[p]
                    ? decode_raw(hi_q[p], sync2_q[p][PIN5], sync2_q[p][PIN8])
                    : 8'h00;

      pad_debounce
`ifdef GAMEPAD_DEBOUNCE_EN
         #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS))
`endif
      u_deb (
         .clk      (clk),
         .reset    (reset),
         .commit   (commit),
         .raw      (raw[p]),
         .stable   (stable[p]),
         .pressed  (pressed[p]),
         .released (released[p])
      );
   end

   assign pad_sel         = (curr_q != SEL_LO);
   assign curr            = curr_q;
   assign rpt.scan_valid  = (curr_q == COMMIT);
   assign rpt.buttons     = stable;
   assign rpt.pressed     = pressed;
   assign rpt.released    = released;
   assign rpt.pad_present = present_q;

endmodule

// File: tb/tb_gamepad_scanner.sv
// Directed bench for gamepad_scanner with NUM_PADS=2, SEL_HOLD=4, SCAN_PERIOD=8, DEBOUNCE_SCANS=2.
// Expectations follow both builds, with or without GAMEPAD_DEBOUNCE_EN.
module tb_gamepad_scanner;

   localparam int NUM_PADS = 2;
`ifdef GAMEPAD_DEBOUNCE_EN
   localparam bit DB_EN = 1'b1;
`else
   localparam bit DB_EN = 1'b0;
`endif
   // The first strobe occupies the 17th cycle after release, seen after the
   // 16th rising edge; later strobes are a full 17-cycle scan apart.
   localparam int FIRST_GAP = 16;
   localparam int SCAN_GAP  = 17;

   logic                  clk = 1'b0;
   logic                  reset = 1'b0;
   logic [6*NUM_PADS-1:0] pad_data;
   logic                  pad_sel;
   logic [1:0]            curr;
   logic [5:0]            p0_hi, p0_lo, p1_hi, p1_lo;

   int tests_run    = 0;
   int tests_failed = 0;

   gamepad_scanner_if #(.NUM_PADS(NUM_PADS)) rpt ();

   gamepad_scanner #(
      .NUM_PADS(NUM_PADS), .SEL_HOLD(4), .SCAN_PERIOD(8), .DEBOUNCE_SCANS(2)
   ) dut (
      .clk(clk), .reset(reset), .pad_data(pad_data),
      .pad_sel(pad_sel), .curr(curr), .rpt(rpt)
   );

   always #5 clk = ~clk;

   // Pad model: the select line chooses which half of each pad drives the pins.
   assign pad_data = pad_sel ? {p1_hi, p0_hi} : {p1_lo, p0_lo};

   task automatic wait_scan(output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!rpt.scan_valid && n < 200);
      if (!rpt.scan_valid) n = -1;
   endtask

   task automatic test_reset;
      int n;
      p0_hi = 6'h3F; p0_lo = 6'h33; p1_hi = 6'h3F; p1_lo = 6'h3F;
      reset = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      tests_run++; if (curr !== 2'd0) begin tests_failed++; $display("FAIL rst_curr: got %0d want 0", curr); end
      tests_run++; if (pad_sel !== 1'b1) begin tests_failed++; $display("FAIL rst_sel: got %b want 1", pad_sel); end
      tests_run++; if (rpt.buttons !== 16'h0000) begin tests_failed++; $display("FAIL rst_buttons: got %h want 0000", rpt.buttons); end
      tests_run++; if (rpt.pad_present !== 2'b00) begin tests_failed++; $display("FAIL rst_present: got %b want 00", rpt.pad_present); end
      tests_run++; if ({rpt.scan_valid, rpt.pressed, rpt.released} !== 33'h0) begin tests_failed++; $display("FAIL rst_pulses: got %h want 0", {rpt.scan_valid, rpt.pressed, rpt.released}); end
      @(negedge clk);
      reset = 1'b1;
      wait_scan(n);
      tests_run++; if (n !== FIRST_GAP) begin tests_failed++; $display("FAIL first_scan_gap: got %0d want %0d", n, FIRST_GAP); end
      tests_run++; if (rpt.pad_present !== 2'b01) begin tests_failed++; $display("FAIL first_present: got %b want 01", rpt.pad_present); end
      tests_run++; if (rpt.buttons !== 16'h0000) begin tests_failed++; $display("FAIL first_buttons: got %h want 0000", rpt.buttons); end
   endtask

   task automatic test_presence;
      int n;
      wait_scan(n);
      tests_run++; if (n !== SCAN_GAP) begin tests_failed++; $display("FAIL scan_gap: got %0d want %0d", n, SCAN_GAP); end
      tests_run++; if (rpt.pad_present !== 2'b01) begin tests_failed++; $display("FAIL presence: got %b want 01", rpt.pad_present); end
      tests_run++; if ({rpt.buttons, rpt.pressed} !== 32'h0) begin tests_failed++; $display("FAIL idle_word: got %h want 0", {rpt.buttons, rpt.pressed}); end
   endtask

   task automatic test_glitch;
      int n;
      @(negedge clk); p0_hi = 6'h3E;
      wait_scan(n);
      @(negedge clk); p0_hi = 6'h3F;
      tests_run++; if (rpt.buttons !== (DB_EN ? 16'h0000 : 16'h0001)) begin tests_failed++; $display("FAIL glitch_buttons: got %h want %h", rpt.buttons, DB_EN ? 16'h0000 : 16'h0001); end
      tests_run++; if (rpt.pressed !== (DB_EN ? 16'h0000 : 16'h0001)) begin tests_failed++; $display("FAIL glitch_pressed: got %h want %h", rpt.pressed, DB_EN ? 16'h0000 : 16'h0001); end
      wait_scan(n);
      tests_run++; if (rpt.buttons !== 16'h0000) begin tests_failed++; $display("FAIL glitch_after: got %h want 0000", rpt.buttons); end
      tests_run++; if (rpt.released !== (DB_EN ? 16'h0000 : 16'h0001)) begin tests_failed++; $display("FAIL glitch_released: got %h want %h", rpt.released, DB_EN ? 16'h0000 : 16'h0001); end
   endtask

   task automatic test_press;
      int n;
      @(negedge clk); p0_lo = 6'h03;
      wait_scan(n);
      tests_run++; if (rpt.buttons !== (DB_EN ? 16'h0000 : 16'h0090)) begin tests_failed++; $display("FAIL press1_buttons: got %h want %h", rpt.buttons, DB_EN ? 16'h0000 : 16'h0090); end
      tests_run++; if (rpt.pressed !== (DB_EN ? 16'h0000 : 16'h0090)) begin tests_failed++; $display("FAIL press1_pressed: got %h want %h", rpt.pressed, DB_EN ? 16'h0000 : 16'h0090); end
      wait_scan(n);
      tests_run++; if (rpt.buttons !== 16'h0090) begin tests_failed++; $display("FAIL press2_buttons: got %h want 0090", rpt.buttons); end
      tests_run++; if (rpt.pressed !== (DB_EN ? 16'h0090 : 16'h0000)) begin tests_failed++; $display("FAIL press2_pressed: got %h want %h", rpt.pressed, DB_EN ? 16'h0090 : 16'h0000); end
      @(posedge clk); #1;
      tests_run++; if ({rpt.scan_valid, rpt.pressed} !== 17'h0) begin tests_failed++; $display("FAIL pulse_width: got %h want 0", {rpt.scan_valid, rpt.pressed}); end
      tests_run++; if (rpt.buttons !== 16'h0090) begin tests_failed++; $display("FAIL press_hold: got %h want 0090", rpt.buttons); end
   endtask

   task automatic test_reset_mid;
      int n;
      int guard;
      guard = 0;
      while (curr !== 2'd2 && guard < 40) begin @(posedge clk); #1; guard++; end
      tests_run++; if (curr !== 2'd2) begin tests_failed++; $display("FAIL reach_sel_lo: got %0d want 2", curr); end
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      tests_run++; if ({pad_sel, curr} !== 3'b100) begin tests_failed++; $display("FAIL midrst_fsm: got sel=%b curr=%0d want sel=1 curr=0", pad_sel, curr); end
      tests_run++; if (rpt.buttons !== 16'h0000) begin tests_failed++; $display("FAIL midrst_buttons: got %h want 0000", rpt.buttons); end
      tests_run++; if (rpt.scan_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_valid: got %b want 0", rpt.scan_valid); end
      @(negedge clk); reset = 1'b1;
      wait_scan(n);
      tests_run++; if (n !== FIRST_GAP) begin tests_failed++; $display("FAIL midrst_gap: got %0d want %0d", n, FIRST_GAP); end
      tests_run++; if (rpt.buttons !== (DB_EN ? 16'h0000 : 16'h0090)) begin tests_failed++; $display("FAIL midrst_scan1: got %h want %h", rpt.buttons, DB_EN ? 16'h0000 : 16'h0090); end
      wait_scan(n);
      tests_run++; if (rpt.buttons !== 16'h0090) begin tests_failed++; $display("FAIL midrst_scan2: got %h want 0090", rpt.buttons); end
   endtask

   task automatic test_release;
      int n;
      @(negedge clk); p0_lo = 6'h33;
      wait_scan(n);
      tests_run++; if (rpt.buttons !== (DB_EN ? 16'h0090 : 16'h0000)) begin tests_failed++; $display("FAIL rel1_buttons: got %h want %h", rpt.buttons, DB_EN ? 16'h0090 : 16'h0000); end
      tests_run++; if (rpt.released !== (DB_EN ? 16'h0000 : 16'h0090)) begin tests_failed++; $display("FAIL rel1_released: got %h want %h", rpt.released, DB_EN ? 16'h0000 : 16'h0090); end
      wait_scan(n);
      tests_run++; if (rpt.buttons !== 16'h0000) begin tests_failed++; $display("FAIL rel2_buttons: got %h want 0000", rpt.buttons); end
      tests_run++; if (rpt.released !== (DB_EN ? 16'h0090 : 16'h0000)) begin tests_failed++; $display("FAIL rel2_released: got %h want %h", rpt.released, DB_EN ? 16'h0090 : 16'h0000); end
   endtask

   task automatic test_pad1_removal;
      int n;
      @(negedge clk); p1_hi = 6'h2F; p1_lo = 6'h33;
      wait_scan(n);
      tests_run++; if (rpt.pad_present !== 2'b11) begin tests_failed++; $display("FAIL pad1_present: got %b want 11", rpt.pad_present); end
      tests_run++; if (rpt.buttons !== (DB_EN ? 16'h0000 : 16'h2000)) begin tests_failed++; $display("FAIL pad1_scan1: got %h want %h", rpt.buttons, DB_EN ? 16'h0000 : 16'h2000); end
      wait_scan(n);
      tests_run++; if (rpt.buttons !== 16'h2000) begin tests_failed++; $display("FAIL pad1_scan2: got %h want 2000", rpt.buttons); end
      @(negedge clk); p1_lo = 6'h3F;
      wait_scan(n);
      tests_run++; if (rpt.pad_present !== 2'b01) begin tests_failed++; $display("FAIL pad1_gone: got %b want 01", rpt.pad_present); end
      tests_run++; if (rpt.released !== (DB_EN ? 16'h0000 : 16'h2000)) begin tests_failed++; $display("FAIL rm1_released: got %h want %h", rpt.released, DB_EN ? 16'h0000 : 16'h2000); end
      wait_scan(n);
      tests_run++; if (rpt.buttons !== 16'h0000) begin tests_failed++; $display("FAIL rm2_buttons: got %h want 0000", rpt.buttons); end
      tests_run++; if (rpt.released !== (DB_EN ? 16'h2000 : 16'h0000)) begin tests_failed++; $display("FAIL rm2_released: got %h want %h", rpt.released, DB_EN ? 16'h2000 : 16'h0000); end
   endtask

   initial begin
      test_reset();
      test_presence();
      test_glitch();
      test_press();
      test_reset_mid();
      test_release();
      test_pad1_removal();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
